// File: rtl/ibex_instr_bus_arbiter.sv
// rtl/ibex_instr_bus_arbiter.sv - two-requester instruction fetch arbiter with in-order response routing
// Optional IBEX_INSTR_ARB_RR_EN selects round-robin instead of fixed m0-first priority.
module ibex_instr_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    localparam int IdxW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            m0_req_i,
    input  logic [31:0]     m0_addr_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    input  logic            m1_req_i,
    input  logic [31:0]     m1_addr_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [31:0]     rdata_o,
    output logic            err_o,
    output logic            instr_req_o,
    output logic [31:0]     instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [31:0]     instr_rdata_i,
    input  logic            instr_err_i,
    output logic [IdxW:0]   outstanding_o,
    output logic            busy_o,
    output logic            spurious_rvalid_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    localparam logic [IdxW:0]   MaxCnt  = (IdxW+1)'(MAX_OUTSTANDING);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(MAX_OUTSTANDING - 1);

    state_e                     state_q, state_d;
    logic                       lock_q, lock_d;
    logic                       pri_sel, sel, lock_hold, space, bus_gnt;
    logic                       empty, push, pop, head;
    logic [31:0]                sel_addr;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [IdxW-1:0]            wptr_q, rptr_q;
    logic [IdxW:0]              cnt_q;
    logic                       spurious_q;
    logic                       unused_addr_bits;

`ifdef IBEX_INSTR_ARB_RR_EN
    logic prio_q;

    // Priority pointer always points at the requester that lost the last grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (bus_gnt) begin
            prio_q <= ~sel;
        end
    end

    assign pri_sel = (m0_req_i & m1_req_i) ? prio_q : m1_req_i;
`else
    assign pri_sel = m1_req_i & ~m0_req_i;
`endif

    // A lock only holds while its owner still requests; a dropped request falls back to priority.
    assign lock_hold = (state_q == LOCKED) & (lock_q ? m1_req_i : m0_req_i);
    assign sel       = lock_hold ? lock_q : pri_sel;

    assign space        = (cnt_q < MaxCnt);
    assign instr_req_o  = space & (m0_req_i | m1_req_i);
    assign bus_gnt      = instr_req_o & instr_gnt_i;
    assign sel_addr     = sel ? m1_addr_i : m0_addr_i;
    assign instr_addr_o = {sel_addr[31:2], 2'b00};
    assign m0_gnt_o     = bus_gnt & ~sel;
    assign m1_gnt_o     = bus_gnt & sel;
    assign unused_addr_bits = ^sel_addr[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (instr_req_o && !instr_gnt_i) begin
                    state_d = LOCKED;
                    lock_d  = sel;
                end
            end
            LOCKED: begin
                if (!lock_hold) begin
                    if (instr_req_o && !instr_gnt_i) begin
                        lock_d = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus_gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign push  = bus_gnt;
    assign pop   = instr_rvalid_i & ~empty;
    assign head  = owner_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wptr_q] <= sel;
                wptr_q          <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (instr_rvalid_i && empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign m0_rvalid_o       = pop & ~head;
    assign m1_rvalid_o       = pop & head;
    assign rdata_o           = instr_rdata_i;
    assign err_o             = instr_err_i;
    assign outstanding_o     = cnt_q;
    assign busy_o            = (cnt_q != '0) | instr_req_o;
    assign spurious_rvalid_o = spurious_q;

endmodule

// File: doc/ibex_instr_bus_arbiter.md
Name: ibex_instr_bus_arbiter

Overview:
- Shares the single instruction memory port between two fetch requesters: m0 is the prefetch buffer and m1 is a secondary fetcher (debug ROM or ICache refill).
- Arbitrates the address phase and tracks granted transactions in an in-order ID queue, so each rvalid/rdata is routed back to the correct requester.
- Sits between the core fetch stage and the instruction bus/PMP boundary.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered downstream transactions. Legal range 1..8.
- IdxW, $clog2(MAX_OUTSTANDING) (min 1), derived, queue pointer width. Not user-settable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m0_req_i  in  1  prefetch buffer request.
- m0_addr_i  in  32  prefetch buffer address.
- m0_gnt_o  out  1  grant to m0.
- m0_rvalid_o  out  1  response valid to m0.
- m1_req_i  in  1  secondary requester request.
- m1_addr_i  in  32  secondary requester address.
- m1_gnt_o  out  1  grant to m1.
- m1_rvalid_o  out  1  response valid to m1.
- rdata_o  out  32  response data, broadcast to both requesters.
- err_o  out  1  response error, broadcast to both requesters.
- instr_req_o  out  1  bus request.
- instr_addr_o  out  32  bus address, word aligned ([1:0]=0).
- instr_gnt_i  in  1  bus grant.
- instr_rvalid_i  in  1  bus response valid.
- instr_rdata_i  in  32  bus response data.
- instr_err_i  in  1  bus response error.
- outstanding_o  out  IdxW+1  number of granted transactions still awaiting rvalid.
- busy_o  out  1  outstanding_o!=0 | instr_req_o.
- spurious_rvalid_o  out  1  sticky flag: rvalid received while queue empty.

Behaviour:
- Reset values: all outputs 0, queue empty, lock clear, priority pointer = m0.
- Address phase:
  - space = (outstanding_q < MAX_OUTSTANDING). Full is decided on the registered count only; a same-cycle rvalid does not free a slot.
  - instr_req_o = space & (m0_req_i | m1_req_i). Both requesters must hold req/addr stable until granted.
  - sel is the requester driving instr_addr_o; instr_addr_o = {sel_addr[31:2], 2'b00}.
  - gnt is combinational: mX_gnt_o = instr_req_o & instr_gnt_i & (sel==X). Never both grants in one cycle.
- Selection state machine, states IDLE and LOCKED:
  - IDLE: sel is chosen by priority (fixed m0 first, unless the optional feature is compiled in). If instr_req_o & ~instr_gnt_i, latch sel and go to LOCKED.
  - LOCKED: sel is held regardless of the other requester. Go to IDLE on instr_gnt_i.
  - LOCKED when the locked requester drops req (protocol violation): return to IDLE. Does not fire an assertion in synthesis.
  - Queue full while LOCKED: instr_req_o is deasserted and the lock is kept.
- ID queue (circular, MAX_OUTSTANDING entries of 1-bit owner):
  - Push sel on instr_req_o & instr_gnt_i.
  - Pop on instr_rvalid_i & ~empty.
  - Push and pop in the same cycle: count unchanged, both pointers advance, wrap modulo MAX_OUTSTANDING.
- Response routing:
  - mX_rvalid_o = instr_rvalid_i & ~empty & (head owner==X).
  - rdata_o and err_o pass through combinationally. Zero-cycle latency on the response path.
- instr_rvalid_i while empty: no rvalid forwarded, count unchanged, spurious_rvalid_o set to 1 until reset.
- Reset asserted mid-transaction: queue cleared. Responses still in flight after reset release are spurious and set the flag.
- Branch flushes inside requesters do not affect the arbiter. Discarding stale responses is the requester's job.

Optional Feature:
- IBEX_INSTR_ARB_RR_EN defined: round-robin arbitration. After each grant in IDLE or LOCKED, the priority pointer moves to the non-granted requester. With both requesters continuously asserting, grants alternate m0, m1, m0, ...
- Undefined: fixed priority, m0 always wins in IDLE. m1 can starve while m0 keeps requesting.

Test Plan:
- Single m0 request, addr 0x0000_1002, gnt same cycle, rvalid next cycle with rdata 0xDEAD_BEEF -> instr_addr_o=0x0000_1000; m0_gnt_o=1, then m0_rvalid_o=1 with rdata_o=0xDEAD_BEEF; m1_rvalid_o=0.
- m0 and m1 request at 0x100 and 0x200; gnt withheld 3 cycles, then m0_req drops while m1 holds -> instr_addr_o stays 0x100 for the 3 stall cycles; lock then releases and m1 is granted at 0x200.
- MAX_OUTSTANDING=2: three back-to-back grants attempted with no rvalid -> instr_req_o=0 after 2 grants, outstanding_o=2; the first rvalid drops it to 1; the third request issues the following cycle.
- Interleaved grants m0, m1, m0, then three rvalids -> rvalid routed m0, m1, m0 in order; a push/pop in the same cycle at the queue wrap keeps outstanding_o constant.
- instr_rvalid_i=1 with an empty queue -> no mX_rvalid_o; spurious_rvalid_o=1 and held; cleared only by rst_ni=0.
- With IBEX_INSTR_ARB_RR_EN, both requesting continuously, gnt always 1 -> grants m0, m1, m0, m1. Without it -> m0 granted every cycle.
